score_board: RTL and testbench

SCORE_BOARD -- requirements
Module: score_board

---
 rtl/score_board.sv | 250 +++++++++++++++++++++++++
 tb/tb_score_board.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_board.sv
// score_board: queues bus transaction records in a 4-deep FIFO and accumulates
// completion, latency and routing statistics, plus an on-demand average-latency report.
module score_board #(
  parameter int drvrs   = 4,
  parameter int pckg_sz = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [pckg_sz-1:0]     dato_enviado,
  input  logic [31:0]            tiempo_push,
  input  logic [31:0]            tiempo_pop,
  input  logic                   completado,
  input  logic [31:0]            latencia,
  input  logic [7:0]             dsp_env,
  input  logic [7:0]             dsp_rec,
  input  logic                   rpt_req,
  output logic [15:0]            trans_count,
  output logic [15:0]            done_count,
  output logic [15:0]            drop_count,
  output logic [39:0]            lat_sum,
  output logic [31:0]            lat_max,
  output logic [31:0]            lat_min,
  output logic [15:0]            lat_err_count,
  output logic [15:0]            dst_err_count,
  output logic [drvrs*16-1:0]    rx_count,
  output logic                   rpt_busy,
  output logic                   rpt_done,
  output logic [31:0]            avg_lat
);

  localparam logic [31:0] DRVRS_W = 32'(drvrs);

  typedef struct packed {
    logic [pckg_sz-1:0] dato;
    logic [7:0]         env;
    logic [31:0]        tpush;
    logic [31:0]        tpop;
    logic               comp;
    logic [31:0]        lat;
    logic [7:0]         rec;
  } rec_t;

  rec_t               fifo_r [4];
  logic [1:0]         wr_ptr_r;
  logic [1:0]         rd_ptr_r;
  logic [2:0]         count_r;
  logic [2:0]         count_next_s;
  logic               in_ready_r;
  logic               push_s;
  logic               pop_s;
  rec_t               head_s;

  logic               stage_valid_r;
  logic               stage_comp_r;
  logic               stage_lat_bad_r;
  logic               stage_dst_bad_r;
  logic [31:0]        stage_lat_r;
  logic [7:0]         stage_rec_r;

  logic [15:0]        trans_count_r;
  logic [15:0]        done_count_r;
  logic [15:0]        drop_count_r;
  logic [39:0]        lat_sum_r;
  logic [31:0]        lat_max_r;
  logic [31:0]        lat_min_r;
  logic [15:0]        lat_err_count_r;
  logic [15:0]        dst_err_count_r;
  logic [drvrs*16-1:0] rx_count_r;

  logic               rpt_busy_r;
  logic               rpt_done_r;
  logic [31:0]        avg_lat_r;
  logic [15:0]        div_r;
  logic [39:0]        quo_r;
  logic [15:0]        rem_r;
  logic [5:0]         step_r;
  logic [16:0]        rem_shift_s;
  logic [15:0]        rem_next_s;
  logic [39:0]        quo_next_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [39:0] sat_add40(input logic [39:0] a, input logic [31:0] b);
    logic [40:0] s;
    s = {1'b0, a} + {9'd0, b};
    sat_add40 = s[40] ? 40'hFF_FFFF_FFFF : s[39:0];
  endfunction

  function automatic logic [31:0] clamp32(input logic [39:0] v);
    clamp32 = (v[39:32] != 8'd0) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  // Handshake decode; pops freeze while a report is dividing
  always_comb begin
    push_s       = in_valid && in_ready_r;
    pop_s        = (count_r != 3'd0) && !rpt_busy_r;
    head_s       = fifo_r[rd_ptr_r];
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + 3'd1;
      2'b01:   count_next_s = count_r - 3'd1;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= 2'd0;
      rd_ptr_r   <= 2'd0;
      count_r    <= 3'd0;
      in_ready_r <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + 2'd1;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + 2'd1;
      count_r    <= count_next_s;
      in_ready_r <= (count_next_s != 3'd4);
    end
  end

  // FIFO storage needs no reset: emptiness is carried by the pointers
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_r[wr_ptr_r] <= '{dato: dato_enviado, env: dsp_env, tpush: tiempo_push,
                            tpop: tiempo_pop, comp: completado, lat: latencia, rec: dsp_rec};
    end
  end

  // Pop stage: classify the head record one cycle before statistics update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid_r   <= 1'b0;
      stage_comp_r    <= 1'b0;
      stage_lat_bad_r <= 1'b0;
      stage_dst_bad_r <= 1'b0;
      stage_lat_r     <= 32'd0;
      stage_rec_r     <= 8'd0;
    end else begin
      stage_valid_r <= pop_s;
      if (pop_s) begin
        stage_comp_r    <= head_s.comp;
        stage_lat_r     <= head_s.lat;
        stage_lat_bad_r <= (head_s.lat != (head_s.tpush - head_s.tpop));
        stage_dst_bad_r <= ({24'd0, head_s.rec} >= DRVRS_W);
        stage_rec_r     <= head_s.rec;
      end
    end
  end

  // Statistics accumulation, all saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trans_count_r   <= 16'd0;
      done_count_r    <= 16'd0;
      drop_count_r    <= 16'd0;
      lat_sum_r       <= 40'd0;
      lat_max_r       <= 32'd0;
      lat_min_r       <= 32'hFFFF_FFFF;
      lat_err_count_r <= 16'd0;
      dst_err_count_r <= 16'd0;
      rx_count_r      <= '0;
    end else if (stage_valid_r) begin
      trans_count_r <= sat_inc(trans_count_r);
      if (stage_comp_r) begin
        done_count_r <= sat_inc(done_count_r);
        lat_sum_r    <= sat_add40(lat_sum_r, stage_lat_r);
        if (stage_lat_r > lat_max_r) lat_max_r <= stage_lat_r;
        if (stage_lat_r < lat_min_r) lat_min_r <= stage_lat_r;
        if (stage_lat_bad_r) lat_err_count_r <= sat_inc(lat_err_count_r);
        for (int i = 0; i < drvrs; i++) begin
          if (!stage_dst_bad_r && (32'(stage_rec_r) == 32'(i)))
            rx_count_r[i*16 +: 16] <= sat_inc(rx_count_r[i*16 +: 16]);
        end
      end else begin
        drop_count_r <= sat_inc(drop_count_r);
      end
      if (stage_dst_bad_r) dst_err_count_r <= sat_inc(dst_err_count_r);
    end
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    rem_shift_s = {rem_r, quo_r[39]};
    if (rem_shift_s >= {1'b0, div_r}) begin
      rem_next_s = 16'(rem_shift_s - {1'b0, div_r});
      quo_next_s = {quo_r[38:0], 1'b1};
    end else begin
      rem_next_s = rem_shift_s[15:0];
      quo_next_s = {quo_r[38:0], 1'b0};
    end
  end

  // Report sequencer: operands are latched at start, 40 steps, then a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_busy_r <= 1'b0;
      rpt_done_r <= 1'b0;
      avg_lat_r  <= 32'd0;
      div_r      <= 16'd0;
      quo_r      <= 40'd0;
      rem_r      <= 16'd0;
      step_r     <= 6'd0;
    end else if (rpt_busy_r) begin
      quo_r <= quo_next_s;
      rem_r <= rem_next_s;
      if (step_r == 6'd39) begin
        rpt_busy_r <= 1'b0;
        rpt_done_r <= 1'b1;
        avg_lat_r  <= clamp32(quo_next_s);
        step_r     <= 6'd0;
      end else begin
        rpt_done_r <= 1'b0;
        step_r     <= step_r + 6'd1;
      end
    end else if (rpt_req) begin
      if (done_count_r == 16'd0) begin
        avg_lat_r  <= 32'd0;
        rpt_done_r <= 1'b1;
      end else begin
        rpt_busy_r <= 1'b1;
        rpt_done_r <= 1'b0;
        div_r      <= done_count_r;
        quo_r      <= lat_sum_r;
        rem_r      <= 16'd0;
        step_r     <= 6'd0;
      end
    end else begin
      rpt_done_r <= 1'b0;
    end
  end

  assign in_ready      = in_ready_r;
  assign trans_count   = trans_count_r;
  assign done_count    = done_count_r;
  assign drop_count    = drop_count_r;
  assign lat_sum       = lat_sum_r;
  assign lat_max       = lat_max_r;
  assign lat_min       = lat_min_r;
  assign lat_err_count = lat_err_count_r;
  assign dst_err_count = dst_err_count_r;
  assign rx_count      = rx_count_r;
  assign rpt_busy      = rpt_busy_r;
  assign rpt_done      = rpt_done_r;
  assign avg_lat       = avg_lat_r;

endmodule

// File: tb/tb_score_board.sv
// Bench for score_board: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_score_board;
  localparam int DRVRS = 4;
  localparam int PSZ   = 16;
  localparam longint unsigned SUM_MAX = 64'h0000_00FF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [PSZ-1:0] dato_enviado = '0;
  logic [31:0] tiempo_push = '0, tiempo_pop = '0, latencia = '0;
  logic completado = 1'b0;
  logic [7:0] dsp_env = '0, dsp_rec = '0;
  logic rpt_req = 1'b0;
  logic [15:0] trans_count, done_count, drop_count, lat_err_count, dst_err_count;
  logic [39:0] lat_sum;
  logic [31:0] lat_max, lat_min, avg_lat;
  logic [DRVRS*16-1:0] rx_count;
  logic rpt_busy, rpt_done;

  score_board #(.drvrs(DRVRS), .pckg_sz(PSZ)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dato_enviado(dato_enviado), .tiempo_push(tiempo_push), .tiempo_pop(tiempo_pop),
    .completado(completado), .latencia(latencia), .dsp_env(dsp_env), .dsp_rec(dsp_rec),
    .rpt_req(rpt_req), .trans_count(trans_count), .done_count(done_count),
    .drop_count(drop_count), .lat_sum(lat_sum), .lat_max(lat_max), .lat_min(lat_min),
    .lat_err_count(lat_err_count), .dst_err_count(dst_err_count), .rx_count(rx_count),
    .rpt_busy(rpt_busy), .rpt_done(rpt_done), .avg_lat(avg_lat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        comp;
    logic [31:0] tpush;
    logic [31:0] tpop;
    logic [31:0] lat;
    logic [7:0]  rec;
  } mrec_t;

  // Reference model state: queued records, the record in flight, and statistics
  mrec_t mq[$];
  mrec_t m_p;
  bit m_pv;
  int m_trans, m_cdone, m_drop, m_lerr, m_derr, m_left;
  int m_rx[DRVRS];
  longint unsigned m_sum;
  logic [31:0] m_max, m_min, m_avg, m_pavg;
  bit m_busy, m_rdone;

  int n_err = 0;
  int n_chk = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_pv = 1'b0;
    m_trans = 0; m_cdone = 0; m_drop = 0; m_lerr = 0; m_derr = 0; m_left = 0;
    for (int i = 0; i < DRVRS; i++) m_rx[i] = 0;
    m_sum = 0; m_max = 32'd0; m_min = 32'hFFFF_FFFF;
    m_avg = 32'd0; m_pavg = 32'd0; m_busy = 1'b0; m_rdone = 1'b0;
  endtask

  initial begin : model
    bit old_busy;
    int old_size;
    longint unsigned qq;
    logic [31:0] diff;
    mrec_t r;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_reset();
      end else begin
        old_busy = m_busy;
        old_size = mq.size();
        // report decision sees the statistics as they stood before this edge
        m_rdone = 1'b0;
        if (m_busy) begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 1'b0; m_rdone = 1'b1; m_avg = m_pavg;
          end
        end else if (rpt_req) begin
          if (m_cdone == 0) begin
            m_avg = 32'd0; m_rdone = 1'b1;
          end else begin
            qq = m_sum / longint'(m_cdone);
            m_pavg = (qq > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : 32'(qq);
            m_busy = 1'b1; m_left = 40;
          end
        end
        if (m_pv) begin
          m_trans = sat16(m_trans);
          if (m_p.comp) begin
            m_cdone = sat16(m_cdone);
            m_sum = m_sum + 64'(m_p.lat);
            if (m_sum > SUM_MAX) m_sum = SUM_MAX;
            if (m_p.lat > m_max) m_max = m_p.lat;
            if (m_p.lat < m_min) m_min = m_p.lat;
            diff = m_p.tpush - m_p.tpop;
            if (m_p.lat != diff) m_lerr = sat16(m_lerr);
            if (int'(m_p.rec) < DRVRS) m_rx[m_p.rec] = sat16(m_rx[m_p.rec]);
          end else begin
            m_drop = sat16(m_drop);
          end
          if (int'(m_p.rec) >= DRVRS) m_derr = sat16(m_derr);
        end
        m_pv = 1'b0;
        if (old_size > 0 && !old_busy) begin
          m_p = mq.pop_front();
          m_pv = 1'b1;
        end
        if (in_valid && old_size < 4) begin
          r.comp = completado; r.tpush = tiempo_push; r.tpop = tiempo_pop;
          r.lat = latencia; r.rec = dsp_rec;
          mq.push_back(r);
        end
      end
    end
  end

  initial begin : compare
    logic [63:0] rx_exp;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        rx_exp = '0;
        for (int i = 0; i < DRVRS; i++) rx_exp[i*16 +: 16] = 16'(m_rx[i]);
        chk("in_ready", 64'(in_ready), 64'(mq.size() < 4));
        chk("trans_count", 64'(trans_count), 64'(m_trans));
        chk("done_count", 64'(done_count), 64'(m_cdone));
        chk("drop_count", 64'(drop_count), 64'(m_drop));
        chk("lat_sum", 64'(lat_sum), m_sum);
        chk("lat_max", 64'(lat_max), 64'(m_max));
        chk("lat_min", 64'(lat_min), 64'(m_min));
        chk("lat_err_count", 64'(lat_err_count), 64'(m_lerr));
        chk("dst_err_count", 64'(dst_err_count), 64'(m_derr));
        chk("rx_count", 64'(rx_count), rx_exp);
        chk("rpt_busy", 64'(rpt_busy), 64'(m_busy));
        chk("rpt_done", 64'(rpt_done), 64'(m_rdone));
        chk("avg_lat", 64'(avg_lat), 64'(m_avg));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] dt, input logic cp, input logic [31:0] tp,
                      input logic [31:0] tq, input logic [31:0] lt,
                      input logic [7:0] ev, input logic [7:0] rc);
    int n = 0;
    dato_enviado = dt; completado = cp; tiempo_push = tp; tiempo_pop = tq;
    latencia = lt; dsp_env = ev; dsp_rec = rc; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    chk("send_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic report_pulse();
    rpt_req = 1'b1;
    tick();
    rpt_req = 1'b0;
  endtask

  initial begin : stim
    int cnt;
    logic [31:0] tp, tq, lt;
    repeat (3) tick();
    rst_n = 1'b1;
    cmp_en = 1'b1;
    chk("rst_trans", 64'(trans_count), 64'd0);
    chk("rst_lat_min", 64'(lat_min), 64'hFFFF_FFFF);
    chk("rst_lat_max", 64'(lat_max), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_avg", 64'(avg_lat), 64'd0);

    // Two clean records, first one checked for its two-cycle latency
    send(16'h00AB, 1'b1, 32'd20, 32'd12, 32'd8, 8'd1, 8'd0);
    tick();
    chk("lat1_trans", 64'(trans_count), 64'd0);
    tick();
    chk("lat2_trans", 64'(trans_count), 64'd1);
    send(16'h01FF, 1'b1, 32'd24, 32'd16, 32'd8, 8'd2, 8'd1);
    repeat (3) tick();
    chk("two_trans", 64'(trans_count), 64'd2);
    chk("two_done", 64'(done_count), 64'd2);
    chk("two_sum", 64'(lat_sum), 64'd16);
    chk("two_max", 64'(lat_max), 64'd8);
    chk("two_min", 64'(lat_min), 64'd8);
    chk("two_rx0", 64'(rx_count[15:0]), 64'd1);
    chk("two_rx1", 64'(rx_count[31:16]), 64'd1);
    chk("two_lat_err", 64'(lat_err_count), 64'd0);
    chk("model_two_trans", 64'(m_trans), 64'd2);
    chk("model_two_sum", m_sum, 64'd16);

    // Report: 40 busy cycles, then a done pulse with avg 16/2
    report_pulse();
    cnt = 0;
    while (rpt_busy && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("rpt_cycles", 64'(cnt), 64'd40);
    chk("rpt_done_pulse", 64'(rpt_done), 64'd1);
    chk("rpt_avg", 64'(avg_lat), 64'd8);
    chk("model_rpt_avg", 64'(m_avg), 64'd8);
    tick();
    chk("rpt_done_clear", 64'(rpt_done), 64'd0);
    chk("rpt_avg_hold", 64'(avg_lat), 64'd8);

    // Latency mismatch
    send(16'h1234, 1'b1, 32'd24, 32'd16, 32'd9, 8'd0, 8'd2);
    repeat (3) tick();
    chk("mis_lat_err", 64'(lat_err_count), 64'd1);
    chk("mis_sum", 64'(lat_sum), 64'd25);
    chk("mis_max", 64'(lat_max), 64'd9);
    chk("mis_rx2", 64'(rx_count[47:32]), 64'd1);

    // Dropped record to an out-of-range destination
    send(16'h5555, 1'b0, 32'd100, 32'd50, 32'd7, 8'd3, 8'd5);
    repeat (3) tick();
    chk("drop_drop", 64'(drop_count), 64'd1);
    chk("drop_dst_err", 64'(dst_err_count), 64'd1);
    chk("drop_sum", 64'(lat_sum), 64'd25);
    chk("drop_min", 64'(lat_min), 64'd8);
    chk("drop_done", 64'(done_count), 64'd3);
    chk("drop_trans", 64'(trans_count), 64'd4);

    // Back-pressure while a report stalls the pops
    report_pulse();
    for (int k = 0; k < 4; k++)
      send(16'(k), 1'b1, 32'(1000 + k * 10), 32'd1000, 32'(k * 10), 8'd0, 8'd3);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_busy", 64'(rpt_busy), 64'd1);
    send(16'd4, 1'b1, 32'd1040, 32'd1000, 32'd40, 8'd0, 8'd3);
    repeat (10) tick();
    chk("bp_trans", 64'(trans_count), 64'd9);
    chk("bp_rx3", 64'(rx_count[63:48]), 64'd5);
    chk("bp_sum", 64'(lat_sum), 64'd125);
    chk("bp_avg", 64'(avg_lat), 64'd8);

    // Reset with records queued behind a running report
    report_pulse();
    for (int k = 0; k < 3; k++)
      send(16'(k), 1'b1, 32'd50, 32'd40, 32'd10, 8'd0, 8'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_trans", 64'(trans_count), 64'd0);
    chk("mid_rst_done", 64'(done_count), 64'd0);
    chk("mid_rst_sum", 64'(lat_sum), 64'd0);
    chk("mid_rst_min", 64'(lat_min), 64'hFFFF_FFFF);
    chk("mid_rst_rx", 64'(rx_count), 64'd0);
    chk("mid_rst_busy", 64'(rpt_busy), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_avg", 64'(avg_lat), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_rst_trans", 64'(trans_count), 64'd0);
    chk("post_rst_busy", 64'(rpt_busy), 64'd0);

    // Random traffic, occasional reports
    for (int c = 0; c < 1500; c++) begin
      tp = $urandom;
      tq = $urandom;
      lt = ($urandom_range(0, 99) < 80) ? (tp - tq) : $urandom;
      in_valid     = ($urandom_range(0, 99) < 60);
      completado   = ($urandom_range(0, 3) != 0);
      tiempo_push  = tp;
      tiempo_pop   = tq;
      latencia     = lt;
      dsp_rec      = 8'($urandom_range(0, 6));
      dsp_env      = 8'($urandom);
      dato_enviado = 16'($urandom);
      rpt_req      = ($urandom_range(0, 99) < 3);
      tick();
    end
    in_valid = 1'b0;
    rpt_req = 1'b0;
    repeat (50) tick();

    // Near-maximal latencies to drive lat_sum into saturation
    for (int c = 0; c < 700; c++) begin
      tq = $urandom;
      lt = 32'hFFFF_FFFF - 32'($urandom_range(0, 255));
      in_valid    = 1'b1;
      completado  = 1'b1;
      tiempo_pop  = tq;
      tiempo_push = tq + lt;
      latencia    = lt;
      dsp_rec     = 8'($urandom_range(0, 3));
      tick();
    end
    in_valid = 1'b0;
    repeat (10) tick();
    chk("sat_lat_sum", 64'(lat_sum), 64'h00FF_FFFF_FFFF);
    chk("model_sat_sum", m_sum, 64'h00FF_FFFF_FFFF);
    report_pulse();
    cnt = 0;
    while (!rpt_done && cnt < 60) begin
      cnt++;
      tick();
    end
    chk("sat_rpt_done", 64'(rpt_done), 64'd1);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
